// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath widths, NOP opcode and
// operand forward-select encoding.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OP_W-1:0] OP_NOP = 6'h00;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Combinational operand forward selector: EX/MEM beats MEM/WB beats
// register file; register 0 is never forwarded.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int unsigned N  = DATA_W,
  parameter int unsigned RW = REG_W
) (
  input  logic [RW-1:0] src,
  input  logic [N-1:0]  rf_data,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [N-1:0]  exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [N-1:0]  memwb_result,
  output logic [N-1:0]  operand_c
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (exmem_reg_write && (exmem_rd == src) && (src != '0)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd == src) && (src != '0)) begin
      sel = FWD_MEMWB;
    end
  end

  always_comb begin
    case (sel)
      FWD_EXMEM: operand_c = exmem_result;
      FWD_MEMWB: operand_c = memwb_result;
      default:   operand_c = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time forwarding, stall hold with
// MEM/WB operand refresh, flush bubble insertion and a bubble counter.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned N   = DATA_W,
  parameter int unsigned OPW = OP_W,
  parameter int unsigned RW  = REG_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic           stall,
  input  logic           flush,
  input  logic [OPW-1:0] id_opcode,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic [RW-1:0]  id_rd,
  input  logic [N-1:0]   id_rs_data,
  input  logic [N-1:0]   id_rt_data,
  input  logic           id_reg_write,
  input  logic           exmem_reg_write,
  input  logic [RW-1:0]  exmem_rd,
  input  logic [N-1:0]   exmem_result,
  input  logic           memwb_reg_write,
  input  logic [RW-1:0]  memwb_rd,
  input  logic [N-1:0]   memwb_result,
  output logic           ex_valid,
  output logic [OPW-1:0] ex_opcode,
  output logic [N-1:0]   ex_a,
  output logic [N-1:0]   ex_b,
  output logic [RW-1:0]  ex_rs,
  output logic [RW-1:0]  ex_rt,
  output logic [RW-1:0]  ex_rd,
  output logic           ex_reg_write,
  output logic [15:0]    bubble_cnt
);

  logic [N-1:0]   fwd_a_c;
  logic [N-1:0]   fwd_b_c;

  logic           nxt_valid;
  logic [OPW-1:0] nxt_opcode;
  logic [N-1:0]   nxt_a;
  logic [N-1:0]   nxt_b;
  logic [RW-1:0]  nxt_rs;
  logic [RW-1:0]  nxt_rt;
  logic [RW-1:0]  nxt_rd;
  logic           nxt_reg_write;
  logic [15:0]    nxt_bubble_cnt;
  logic           bubble_inc;
  logic           first_cycle_q;

  fwd_mux #(.N(N), .RW(RW)) u_fwd_a (
    .src             (id_rs),
    .rf_data         (id_rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .operand_c       (fwd_a_c)
  );

  fwd_mux #(.N(N), .RW(RW)) u_fwd_b (
    .src             (id_rt),
    .rf_data         (id_rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .operand_c       (fwd_b_c)
  );

  // Next-state selection: flush > stall (hold + MEM/WB refresh) > capture.
  always_comb begin
    nxt_valid     = ex_valid;
    nxt_opcode    = ex_opcode;
    nxt_a         = ex_a;
    nxt_b         = ex_b;
    nxt_rs        = ex_rs;
    nxt_rt        = ex_rt;
    nxt_rd        = ex_rd;
    nxt_reg_write = ex_reg_write;
    bubble_inc    = 1'b0;

    if (flush || (!stall && !id_valid)) begin
      nxt_valid     = 1'b0;
      nxt_opcode    = OPW'(OP_NOP);
      nxt_a         = '0;
      nxt_b         = '0;
      nxt_rs        = '0;
      nxt_rt        = '0;
      nxt_rd        = '0;
      nxt_reg_write = 1'b0;
      bubble_inc    = 1'b1;
    end else if (stall) begin
      // Load-use value may land in MEM/WB while this instruction waits.
      if (memwb_reg_write && (memwb_rd == ex_rs) && (ex_rs != '0)) begin
        nxt_a = memwb_result;
      end
      if (memwb_reg_write && (memwb_rd == ex_rt) && (ex_rt != '0)) begin
        nxt_b = memwb_result;
      end
    end else begin
      nxt_valid     = 1'b1;
      nxt_opcode    = id_opcode;
      nxt_a         = fwd_a_c;
      nxt_b         = fwd_b_c;
      nxt_rs        = id_rs;
      nxt_rt        = id_rt;
      nxt_rd        = id_rd;
      nxt_reg_write = id_reg_write;
    end

    nxt_bubble_cnt = bubble_cnt;
    if (bubble_inc && !first_cycle_q && (bubble_cnt != 16'hFFFF)) begin
      nxt_bubble_cnt = bubble_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_opcode     <= OPW'(OP_NOP);
      ex_a          <= '0;
      ex_b          <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      bubble_cnt    <= '0;
      first_cycle_q <= 1'b1;
    end else begin
      ex_valid      <= nxt_valid;
      ex_opcode     <= nxt_opcode;
      ex_a          <= nxt_a;
      ex_b          <= nxt_b;
      ex_rs         <= nxt_rs;
      ex_rt         <= nxt_rt;
      ex_rd         <= nxt_rd;
      ex_reg_write  <= nxt_reg_write;
      bubble_cnt    <= nxt_bubble_cnt;
      first_cycle_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, stall, flush;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic        id_reg_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write;
  logic [15:0] bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  id_ex_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .stall           (stall),
    .flush           (flush),
    .id_opcode       (id_opcode),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_reg_write    (id_reg_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .ex_valid        (ex_valid),
    .ex_opcode       (ex_opcode),
    .ex_a            (ex_a),
    .ex_b            (ex_b),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .bubble_cnt      (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic rw);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_reg_write = rw;
  endtask

  task automatic set_wb(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                        input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
  endtask

  task automatic chk_bubble(input string tag, input logic [15:0] cnt);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
    chk({tag, ".op"}, 32'(ex_opcode), 32'h00);
    chk({tag, ".a"}, ex_a, 32'h0);
    chk({tag, ".b"}, ex_b, 32'h0);
    chk({tag, ".idx"}, 32'({ex_rs, ex_rt, ex_rd}), 32'h0);
    chk({tag, ".rw"}, 32'(ex_reg_write), 32'd0);
    chk({tag, ".cnt"}, 32'(bubble_cnt), 32'(cnt));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_instr(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(); step();
    chk_bubble("reset", 16'd0);

    // EX/MEM has priority over MEM/WB; first edge out of reset is live
    set_instr(1'b1, 6'h12, 5'd3, 5'd0, 5'd9, 32'h111, 32'h0, 1'b1);
    set_wb(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd3, 32'h5555);
    rst_n = 1'b1;
    step();
    chk("prio.valid", 32'(ex_valid), 32'd1);
    chk("prio.op", 32'(ex_opcode), 32'h12);
    chk("prio.a", ex_a, 32'hAAAA0000);
    chk("prio.b", ex_b, 32'h0);
    chk("prio.rd", 32'(ex_rd), 32'd9);
    chk("prio.rw", 32'(ex_reg_write), 32'd1);

    // Register 0 never forwarded; rs takes MEM/WB
    set_instr(1'b1, 6'h05, 5'd4, 5'd0, 5'd2, 32'h1, 32'h0, 1'b1);
    set_wb(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd4, 32'h4444);
    step();
    chk("r0.b", ex_b, 32'h0);
    chk("r0.a_memwb", ex_a, 32'h4444);

    // Writeback disabled ports ignored; rt forwarded from EX/MEM
    set_instr(1'b1, 6'h07, 5'd5, 5'd6, 5'd11, 32'h5050, 32'h6060, 1'b0);
    set_wb(1'b1, 5'd6, 32'hBEEF, 1'b0, 5'd5, 32'hDEAD);
    step();
    chk("nofwd.a", ex_a, 32'h5050);
    chk("nofwd.b", ex_b, 32'hBEEF);
    chk("nofwd.rw", 32'(ex_reg_write), 32'd0);
    chk("nofwd.cnt", 32'(bubble_cnt), 32'd0);

    // Load-use: capture rs=7, then stall while MEM/WB delivers r7
    set_instr(1'b1, 6'h23, 5'd7, 5'd8, 5'd10, 32'h10, 32'h20, 1'b1);
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("lu.cap_a", ex_a, 32'h10);
    stall = 1'b1;
    set_instr(1'b1, 6'h3F, 5'd7, 5'd1, 5'd1, 32'h77, 32'h78, 1'b0);
    set_wb(1'b1, 5'd7, 32'hCC, 1'b1, 5'd7, 32'h99);
    step();
    chk("lu.a", ex_a, 32'h99);
    chk("lu.b", ex_b, 32'h20);
    chk("lu.op", 32'(ex_opcode), 32'h23);
    chk("lu.rd", 32'(ex_rd), 32'd10);
    chk("lu.valid", 32'(ex_valid), 32'd1);
    chk("lu.cnt", 32'(bubble_cnt), 32'd0);

    // Flush and stall together: flush wins, bubble counted
    flush = 1'b1;
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk_bubble("flush", 16'd1);

    // Stall on a bubble: held, not recounted, r0 never refreshed
    flush = 1'b0;
    set_instr(1'b0, 6'h01, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1);
    set_wb(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    step();
    chk_bubble("stallbub", 16'd1);

    // Capture of id_valid=0 inserts a counted bubble
    stall = 1'b0;
    step();
    chk_bubble("idle", 16'd2);

    // Live capture then asynchronous mid-run reset
    set_instr(1'b1, 6'h2A, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 1'b1);
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("live.valid", 32'(ex_valid), 32'd1);
    chk("live.b", ex_b, 32'h22);
    rst_n = 1'b0;
    #1;
    chk_bubble("midrst", 16'd0);

    // Saturation: 65536 flushes after a live first edge
    step();
    rst_n = 1'b1;
    step();
    chk("sat.live", 32'(ex_valid), 32'd1);
    flush = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    chk("sat.fffe", 32'(bubble_cnt), 32'hFFFE);
    step();
    chk("sat.ffff", 32'(bubble_cnt), 32'hFFFF);
    step();
    chk_bubble("sat.hold", 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
